// File: rtl/s32x_sdr_resp_if.sv
// s32x_sdr_resp_if: SH2 SDRAM request bus plus backend memory port.
// slave  = the responder (s32x_sdr_resp)
// master = the environment (SH2 request logic + memory backend)
interface s32x_sdr_resp_if;
    // SH2 request side
    logic [16:0] SDR_A;
    logic [15:0] SDR_DO;
    logic        SDR_CS;
    logic [1:0]  SDR_WE;
    logic        SDR_RD;
    logic [15:0] SDR_DI;
    logic        SDR_WAIT;
    // backend memory side
    logic [16:0] MEM_A;
    logic [15:0] MEM_D;
    logic [1:0]  MEM_BE;
    logic        MEM_WR;
    logic        MEM_REQ;
    logic        MEM_ACK;
    logic [15:0] MEM_Q;

    modport slave (
        input  SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD, MEM_ACK, MEM_Q,
        output SDR_DI, SDR_WAIT, MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_REQ
    );

    modport master (
        output SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD, MEM_ACK, MEM_Q,
        input  SDR_DI, SDR_WAIT, MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_REQ
    );
endinterface

// File: rtl/s32x_sdr_resp.sv
// s32x_sdr_resp: turns each level-style SH2 SDRAM request into exactly one
// req/ack backend transaction and drives SDR_WAIT as the acknowledge.
// Optional one-entry read cache: define S32X_SDR_RDCACHE_EN.
module s32x_sdr_resp #(
    parameter int MIN_WAIT = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    s32x_sdr_resp_if.slave  bus
);
    localparam logic [3:0] MIN_W = 4'(MIN_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_armed;
    logic [3:0]  r_cnt;
    logic [16:0] r_mem_a;
    logic [15:0] r_mem_d;
    logic [1:0]  r_mem_be;
    logic        r_mem_wr;
    logic        r_mem_req;
    logic        r_wait;
    logic [15:0] r_di;

    logic        w_req_on, w_wr, w_hit;
    logic        w_start, w_ack, w_hold_done;
    logic [3:0]  w_cnt_inc;

    assign w_req_on  = bus.SDR_CS & (bus.SDR_RD | (|bus.SDR_WE));
    assign w_wr      = |bus.SDR_WE;           // RD together with WE counts as a write
    assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

`ifdef S32X_SDR_RDCACHE_EN
    logic        r_cv;
    logic [16:0] r_ctag;
    logic [15:0] r_cdata;

    assign w_hit = r_cv & (r_ctag == bus.SDR_A) & ~w_wr;

    // Cache entry: fill on read completion, merge written bytes on a tag match
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cv    <= 1'b0;
            r_ctag  <= '0;
            r_cdata <= '0;
        end else if (w_ack) begin
            if (!r_mem_wr) begin
                r_cv    <= 1'b1;
                r_ctag  <= r_mem_a;
                r_cdata <= bus.MEM_Q;
            end else if (r_cv && (r_ctag == r_mem_a)) begin
                if (r_mem_be[1]) r_cdata[15:8] <= r_mem_d[15:8];
                if (r_mem_be[0]) r_cdata[7:0]  <= r_mem_d[7:0];
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: cache hits bypass BUSY and go straight to the wait hold
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_req_on && r_armed) w_state_nxt = w_hit ? HOLD : BUSY;
            BUSY: if (bus.MEM_ACK)         w_state_nxt = HOLD;
            HOLD: if (r_cnt >= MIN_W)      w_state_nxt = DONE;
            DONE:                          w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath
    always_comb begin
        w_start     = (r_state == IDLE) && w_req_on && r_armed;
        w_ack       = (r_state == BUSY) && bus.MEM_ACK;
        w_hold_done = (r_state == HOLD) && (r_cnt >= MIN_W);
    end

    // Datapath: latched request, handshake outputs, wait counter, read data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_armed   <= 1'b1;
            r_cnt     <= '0;
            r_mem_a   <= '0;
            r_mem_d   <= '0;
            r_mem_be  <= '0;
            r_mem_wr  <= 1'b0;
            r_mem_req <= 1'b0;
            r_wait    <= 1'b0;
            r_di      <= '0;
        end else begin
            // one access per request: re-arm only once REQ_ON has dropped
            if (!w_req_on)    r_armed <= 1'b1;
            else if (w_start) r_armed <= 1'b0;

            case (r_state)
                IDLE: if (w_start) begin
                    r_mem_a   <= bus.SDR_A;
                    r_mem_d   <= bus.SDR_DO;
                    r_mem_be  <= bus.SDR_WE;
                    r_mem_wr  <= w_wr;
                    r_mem_req <= ~w_hit;
                    r_wait    <= 1'b1;
                    r_cnt     <= 4'd1;
`ifdef S32X_SDR_RDCACHE_EN
                    if (w_hit) r_di <= r_cdata;
`endif
                end
                BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_wr) r_di <= bus.MEM_Q;
                    end
                end
                HOLD: begin
                    if (w_hold_done) r_wait <= 1'b0;
                    else             r_cnt  <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    assign bus.SDR_DI   = r_di;
    assign bus.SDR_WAIT = r_wait;
    assign bus.MEM_A    = r_mem_a;
    assign bus.MEM_D    = r_mem_d;
    assign bus.MEM_BE   = r_mem_be;
    assign bus.MEM_WR   = r_mem_wr;
    assign bus.MEM_REQ  = r_mem_req;
endmodule

// File: tb/tb_s32x_sdr_resp.sv
// tb_s32x_sdr_resp: directed bench for s32x_sdr_resp (MIN_WAIT=2).
// Backend transactions and read data are predicted into queues as requests
// are driven and checked when the DUT presents them.
module tb_s32x_sdr_resp;
    localparam int MIN_WAIT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    typedef struct {
        logic [16:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        wr;
    } mem_txn_t;

    mem_txn_t    q_mem[$];
    logic [15:0] q_di[$];

    s32x_sdr_resp_if bus();

    s32x_sdr_resp #(.MIN_WAIT(MIN_WAIT)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.SDR_CS = 1'b0;
        bus.SDR_WE = 2'b00;
        bus.SDR_RD = 1'b0;
    endtask

    // Drive one request and follow it to SDR_WAIT low. lat = edges from
    // MEM_REQ rising to the edge that samples MEM_ACK; drop_k > 0 removes
    // the request inputs before edge drop_k.
    task automatic access(input logic [16:0] a, input logic [15:0] d,
                          input logic [1:0] we, input logic rd, input bit be_exp,
                          input int lat, input logic [15:0] q,
                          input logic [15:0] exp_di, input int drop_k);
        mem_txn_t t;
        int wcnt, k, ew;
        ew = be_exp ? ((lat + 1 > MIN_WAIT) ? lat + 1 : MIN_WAIT) : MIN_WAIT;
        @(negedge clk);
        bus.SDR_A  = a;
        bus.SDR_DO = d;
        bus.SDR_WE = we;
        bus.SDR_RD = rd;
        bus.SDR_CS = 1'b1;
        if (be_exp) q_mem.push_back('{a, d, we, |we});
        q_di.push_back(exp_di);
        @(posedge clk); #1;
        chk("req_rise", bus.MEM_REQ, be_exp);
        chk("wait_rise", bus.SDR_WAIT, 1);
        if (bus.MEM_REQ === 1'b1 && q_mem.size() > 0) begin
            t = q_mem.pop_front();
            chk("mem_a", bus.MEM_A, t.a);
            chk("mem_d", bus.MEM_D, t.d);
            chk("mem_be", bus.MEM_BE, t.be);
            chk("mem_wr", bus.MEM_WR, t.wr);
        end
        wcnt = 1;
        k = 1;
        while (bus.SDR_WAIT === 1'b1 && k < 40) begin
            @(negedge clk);
            bus.MEM_ACK = be_exp && (k == lat);
            bus.MEM_Q   = bus.MEM_ACK ? q : 16'($urandom);
            if (k == drop_k) begin
                bus.SDR_CS = 1'b0;
                bus.SDR_WE = 2'b00;
                bus.SDR_RD = 1'b0;
            end
            @(posedge clk); #1;
            chk("req_hold", bus.MEM_REQ, be_exp && (k < lat));
            if (bus.SDR_WAIT === 1'b1) wcnt++;
            k++;
        end
        @(negedge clk);
        bus.MEM_ACK = 1'b0;
        chk("wait_cycles", wcnt, ew);
        chk("sdr_di", bus.SDR_DI, q_di.pop_front());
    endtask

    initial begin
        int reqs;
        bus.SDR_A   = '0;
        bus.SDR_DO  = '0;
        bus.SDR_CS  = 1'b0;
        bus.SDR_WE  = 2'b00;
        bus.SDR_RD  = 1'b0;
        bus.MEM_ACK = 1'b0;
        bus.MEM_Q   = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait", bus.SDR_WAIT, 0);
        chk("rst_req", bus.MEM_REQ, 0);
        chk("rst_di", bus.SDR_DI, 0);
        chk("rst_a", bus.MEM_A, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // read, ack sampled 3 edges after MEM_REQ -> WAIT high 4 cycles
        access(17'h00010, 16'h0000, 2'b00, 1'b1, 1'b1, 3, 16'hBEEF, 16'hBEEF, -1);
        release_req();

        // lower-byte write at top address, ack in first MEM_REQ cycle
        access(17'h1FFFF, 16'h1234, 2'b01, 1'b0, 1'b1, 1, 16'h0F0F, 16'hBEEF, -1);
        release_req();

        // RD together with WE is a write
        access(17'h00333, 16'hCAFE, 2'b11, 1'b1, 1'b1, 2, 16'h5555, 16'hBEEF, -1);
        release_req();

        // request held long after completion: no second access
        access(17'h00020, 16'h0000, 2'b00, 1'b1, 1'b1, 2, 16'h2222, 16'h2222, -1);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.MEM_REQ === 1'b1 || bus.SDR_WAIT === 1'b1) reqs++;
        end
        chk("held_no_reissue", reqs, 0);
        release_req();
        access(17'h00020, 16'h0000, 2'b00, 1'b1, 1'b1, 2, 16'h3333, 16'h3333, -1);
        release_req();

        // requester drops CS in BUSY: backend and WAIT sequence still complete
        access(17'h0AAAA, 16'h0000, 2'b00, 1'b1, 1'b1, 5, 16'h1357, 16'h1357, 2);
        release_req();

        // async reset during BUSY
        @(negedge clk);
        bus.SDR_A  = 17'h00555;
        bus.SDR_RD = 1'b1;
        bus.SDR_CS = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_req", bus.MEM_REQ, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", bus.MEM_REQ, 0);
        chk("arst_wait", bus.SDR_WAIT, 0);
        chk("arst_di", bus.SDR_DI, 0);
        chk("arst_a", bus.MEM_A, 0);
        bus.SDR_CS = 1'b0;
        bus.SDR_RD = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(17'h00555, 16'h0000, 2'b00, 1'b1, 1'b1, 2, 16'h5A5A, 16'h5A5A, -1);
        release_req();

`ifdef S32X_SDR_RDCACHE_EN
        // read fills cache, upper-byte write merges, re-read hits
        access(17'h00100, 16'h0000, 2'b00, 1'b1, 1'b1, 2, 16'hA5A5, 16'hA5A5, -1);
        release_req();
        access(17'h00100, 16'h7700, 2'b10, 1'b0, 1'b1, 1, 16'h0000, 16'hA5A5, -1);
        release_req();
        access(17'h00100, 16'h0000, 2'b00, 1'b1, 1'b0, 0, 16'h0000, 16'h77A5, -1);
        release_req();
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
